prng_frame_buffer: RTL and testbench

- Bridges the three CA-based PRNG word streams to the VGA pixel driver.
- Each accepted beat packs the three N-bit random words into one display row of 1-bit pixels with fixed gaps, written at an incrementing row pointer.
- A registered read port returns an 8-bit RGB332 colour for any (x,y) requested by the VGA driver.
- Replaces the flat full-frame 8-bit register array with a V_RES x 3N bit store plus a per-row valid map.

---
 rtl/prng_frame_buffer.sv | 90 +++++++++
 tb/tb_prng_frame_buffer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/prng_frame_buffer.sv
// prng_frame_buffer: packs three PRNG words per beat into display rows and serves RGB332 pixels to the VGA driver.
// Ports: i_clk/i_rst (async active-low); i_start restarts the fill; i_rn_0..2 + i_valid/o_ready beat handshake;
// i_rd_x/i_rd_y -> o_color (1-cycle latency); o_row_ptr next row to write; o_busy in FILL; o_frame_done in FULL.
// Optional macro PRNG_FRAME_BUFFER_SCROLL_EN: keep writing in FULL and scroll the read window by the row pointer.
module prng_frame_buffer #(
  parameter int N = 10,
  parameter int GAP = 20,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int XW = 10,
  parameter int YW = 10,
  parameter logic [7:0] C0 = 8'hE0,
  parameter logic [7:0] C1 = 8'h1C,
  parameter logic [7:0] C2 = 8'h03
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [N-1:0]  i_rn_0,
  input  logic [N-1:0]  i_rn_1,
  input  logic [N-1:0]  i_rn_2,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [XW-1:0] i_rd_x,
  input  logic [YW-1:0] i_rd_y,
  output logic [7:0]    o_color,
  output logic [YW-1:0] o_row_ptr,
  output logic          o_busy,
  output logic          o_frame_done
);
  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  localparam int AW = (V_RES > 1) ? $clog2(V_RES) : 1;
`ifdef PRNG_FRAME_BUFFER_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif
  state_t state_q, state_d;
  logic [YW-1:0] row_ptr_q, row_ptr_d;
  logic [V_RES-1:0] valid_q, valid_d;
  logic [7:0] color_q, color_d;
  logic [3*N-1:0] mem_q [V_RES];
  logic xfer, at_last, in_rng, seg0, seg1, seg2;
  logic [YW:0] sum;
  logic [AW-1:0] rd_row, wr_row;
  logic [XW-1:0] idx;
  logic [3*N-1:0] sh;
  always_comb begin
    o_ready = (state_q == FILL || (SCROLL && state_q == FULL)) && !i_start;
    xfer = i_valid && o_ready;
    at_last = row_ptr_q == YW'(V_RES - 1);
    wr_row = AW'(row_ptr_q);
    state_d = i_start ? FILL : (xfer && at_last) ? FULL : state_q;
    row_ptr_d = i_start ? '0 : xfer ? (at_last ? '0 : row_ptr_q + 1'b1) : row_ptr_q;
    valid_d = i_start ? '0 : valid_q;
    if (xfer) valid_d[wr_row] = 1'b1;
    // In scroll mode the display window starts at the oldest row, which is the next one to be overwritten.
    sum = {1'b0, i_rd_y} + (SCROLL ? {1'b0, row_ptr_q} : '0);
    rd_row = AW'(sum >= (YW+1)'(V_RES) ? sum - (YW+1)'(V_RES) : sum);
    in_rng = i_rd_x < XW'(H_RES) && i_rd_y < YW'(V_RES);
    seg0 = i_rd_x < XW'(N);
    seg1 = i_rd_x >= XW'(N + GAP) && i_rd_x < XW'(2*N + GAP);
    seg2 = i_rd_x >= XW'(2*N + 2*GAP) && i_rd_x < XW'(3*N + 2*GAP);
    // Removing the gaps maps column x straight onto its bit in {rn_2, rn_1, rn_0}.
    idx = seg1 ? i_rd_x - XW'(GAP) : seg2 ? i_rd_x - XW'(2*GAP) : i_rd_x;
    sh = mem_q[rd_row] >> idx;
    color_d = !(in_rng && valid_q[rd_row] && sh[0]) ? '0 : seg0 ? C0 : seg1 ? C1 : seg2 ? C2 : '0;
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      row_ptr_q <= '0;
      valid_q <= '0;
      color_q <= '0;
    end else begin
      state_q <= state_d;
      row_ptr_q <= row_ptr_d;
      valid_q <= valid_d;
      color_q <= color_d;
    end
  end
  // Row storage has no reset; the valid map alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (xfer) mem_q[wr_row] <= {i_rn_2, i_rn_1, i_rn_0};
  end
  assign o_color = color_q;
  assign o_row_ptr = row_ptr_q;
  assign o_busy = state_q == FILL;
  assign o_frame_done = state_q == FULL;
endmodule

// File: tb/tb_prng_frame_buffer.sv
// tb_prng_frame_buffer: random and directed checks of prng_frame_buffer against a row-level reference model.
module tb_prng_frame_buffer;
`ifdef PRNG_FRAME_BUFFER_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif
  logic i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_valid = 1'b0;
  logic [9:0] i_rn_0 = '0, i_rn_1 = '0, i_rn_2 = '0, i_rd_x = '0, i_rd_y = '0;
  logic o_ready, o_busy, o_frame_done;
  logic [7:0] o_color;
  logic [9:0] o_row_ptr;
  int vecs = 0, errs = 0;
  logic [9:0] m_w0 [480], m_w1 [480], m_w2 [480];
  bit m_v [480];
  int m_ptr = 0, m_st = 0;
  prng_frame_buffer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_rn_0(i_rn_0), .i_rn_1(i_rn_1),
    .i_rn_2(i_rn_2), .i_valid(i_valid), .o_ready(o_ready), .i_rd_x(i_rd_x), .i_rd_y(i_rd_y),
    .o_color(o_color), .o_row_ptr(o_row_ptr), .o_busy(o_busy), .o_frame_done(o_frame_done)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] exp_color(input int x, input int y);
    int r;
    if (x >= 640 || y >= 480) return 8'h00;
    r = SCROLL ? (y + m_ptr) % 480 : y;
    if (!m_v[r]) return 8'h00;
    if (x < 10) return m_w0[r][x] ? 8'hE0 : 8'h00;
    if (x >= 30 && x < 40) return m_w1[r][x-30] ? 8'h1C : 8'h00;
    if (x >= 60 && x < 70) return m_w2[r][x-60] ? 8'h03 : 8'h00;
    return 8'h00;
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 480; i++) m_v[i] = 1'b0;
    m_ptr = 0;
  endtask
  // One clock: drive inputs, check o_ready, then after the edge check the read result and state outputs.
  task automatic step(input bit v, input bit st, input logic [9:0] r0, r1, r2, input int x, input int y);
    bit rdy;
    logic [7:0] ec;
    i_valid = v; i_start = st; i_rn_0 = r0; i_rn_1 = r1; i_rn_2 = r2;
    i_rd_x = 10'(x); i_rd_y = 10'(y);
    #1;
    rdy = (m_st == 1 || (SCROLL && m_st == 2)) && !st;
    chk("ready", {31'b0, o_ready}, {31'b0, rdy});
    ec = exp_color(x, y);
    @(posedge i_clk);
    if (st) begin
      model_clear();
      m_st = 1;
    end else if (v && rdy) begin
      m_w0[m_ptr] = r0; m_w1[m_ptr] = r1; m_w2[m_ptr] = r2; m_v[m_ptr] = 1'b1;
      if (m_ptr == 479) begin m_ptr = 0; m_st = 2; end else m_ptr++;
    end
    #1;
    chk($sformatf("color(%0d,%0d)", x, y), {24'b0, o_color}, {24'b0, ec});
    chk("row_ptr", {22'b0, o_row_ptr}, m_ptr);
    chk("busy", {31'b0, o_busy}, {31'b0, m_st == 1});
    chk("frame_done", {31'b0, o_frame_done}, {31'b0, m_st == 2});
  endtask
  task automatic rnd_step(input bit v);
    int x;
    x = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 79) : $urandom_range(0, 699);
    step(v, 1'b0, 10'($urandom), 10'($urandom), 10'($urandom), x, $urandom_range(0, 499));
  endtask
  initial begin
    int xs [13] = '{0, 1, 39, 60, 61, 62, 63, 64, 65, 66, 67, 68, 69};
    logic [7:0] ex [13] = '{8'hE0, 8'h00, 8'h1C, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
    int p0;
    model_clear();
    #1 i_rst = 1'b0;
    i_valid = 1'b1; i_rd_x = 10'd0; i_rd_y = 10'd5;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst ready", {31'b0, o_ready}, 0);
    chk("rst row_ptr", {22'b0, o_row_ptr}, 0);
    chk("rst color", {24'b0, o_color}, 0);
    chk("rst done", {31'b0, o_frame_done}, 0);
    chk("rst busy", {31'b0, o_busy}, 0);
    i_rst = 1'b1;
    step(1'b1, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF, 0, 5);
    step(1'b0, 1'b1, 10'h0, 10'h0, 10'h0, 0, 5);
    for (int i = 0; i < 480; i++)
      step(1'b1, 1'b0, 10'h001, 10'h200, 10'h3FF, $urandom_range(0, 79), $urandom_range(0, 479));
    chk("full done", {31'b0, o_frame_done}, 1);
    for (int i = 0; i < 13; i++) begin
      step(1'b0, 1'b0, 10'h0, 10'h0, 10'h0, xs[i], 5);
      chk($sformatf("pattern x=%0d", xs[i]), {24'b0, o_color}, {24'b0, ex[i]});
    end
    step(1'b0, 1'b0, 10'h0, 10'h0, 10'h0, 30, 5);
    chk("gap x=30", {24'b0, o_color}, 0);
    step(1'b0, 1'b0, 10'h0, 10'h0, 10'h0, 650, 5);
    chk("x=650", {24'b0, o_color}, 0);
    step(1'b1, 1'b0, 10'h001, 10'h000, 10'h000, 0, 100);
    step(1'b0, 1'b0, 10'h0, 10'h0, 10'h0, 0, 479);
`ifdef PRNG_FRAME_BUFFER_SCROLL_EN
    chk("scroll ptr", {22'b0, o_row_ptr}, 1);
    chk("scroll newest", {24'b0, o_color}, 8'hE0);
`else
    chk("full hold ptr", {22'b0, o_row_ptr}, 0);
`endif
    step(1'b0, 1'b1, 10'h0, 10'h0, 10'h0, 0, 0);
    for (int i = 0; i < 150; i++) rnd_step(1'($urandom_range(0, 1)));
    p0 = m_ptr;
    for (int i = 0; i < 20; i++) rnd_step(1'(i % 2 == 0));
    chk("backpressure advance", {22'b0, o_row_ptr}, p0 + 10);
    step(1'b0, 1'b1, 10'h0, 10'h0, 10'h0, 0, 0);
    for (int i = 0; i < 100; i++) rnd_step(1'b1);
    step(1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 0, 50);
    chk("start wins ptr", {22'b0, o_row_ptr}, 0);
    step(1'b0, 1'b0, 10'h0, 10'h0, 10'h0, 0, 50);
    chk("row 50 cleared", {24'b0, o_color}, 0);
    for (int i = 0; i < 7; i++) rnd_step(1'b1);
    step(1'b1, 1'b0, 10'h001, 10'h0, 10'h0, 0, 7);
    chk("rbw old", {24'b0, o_color}, 0);
    step(1'b0, 1'b0, 10'h0, 10'h0, 10'h0, 0, 7);
    chk("rbw new", {24'b0, o_color}, 8'hE0);
    for (int i = 0; i < 20; i++) rnd_step(1'b1);
    #2 i_rst = 1'b0;
    #1;
    chk("midrst ptr", {22'b0, o_row_ptr}, 0);
    chk("midrst busy", {31'b0, o_busy}, 0);
    chk("midrst color", {24'b0, o_color}, 0);
    model_clear();
    m_st = 0;
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    step(1'b1, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF, 0, 3);
    step(1'b0, 1'b0, 10'h0, 10'h0, 10'h0, 0, 3);
    chk("midrst row3", {24'b0, o_color}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
